dds_phase_acc: RTL and testbench

DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

---
 rtl/dds_phase_acc.sv | 146 ++++++++++++++
 tb/tb_dds_phase_acc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - DDS phase accumulator with quarter-wave sine LUT folding
//
// Purpose:
//   Phase accumulator for a direct digital synthesiser. It drives an external
//   registered quarter-wave sine LUT and rebuilds a signed full-wave sample.
//   Pipeline: acc (edge N) -> lut_addr (N+1) -> lut_data (N+2) -> sample (N+3).
//
// Optional feature:
//   DDS_PHASE_DITHER_EN - when defined, 16-bit LFSR phase dither is added below
//   the phase LSB before truncation. The accumulator itself is unaffected.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   advance accumulator this cycle
//   ftw_in       in   frequency tuning word (unsigned)
//   ftw_load     in   strobe: latch ftw_in
//   phase_sync   in   strobe: zero the accumulator (overrides en)
//   lut_addr     out  registered quarter-wave LUT address
//   lut_data     in   LUT read data, one clk after lut_addr
//   sample       out  registered signed full-wave sample
//   sample_valid out  sample carries a new value this cycle

module dds_phase_acc #(
  parameter int ACC_WIDTH = 32,
  parameter int LUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] ftw_in,
  input  logic                 ftw_load,
  input  logic                 phase_sync,
  output logic [LUT_WIDTH-1:0] lut_addr,
  input  logic [LUT_WIDTH-1:0] lut_data,
  output logic [LUT_WIDTH:0]   sample,
  output logic                 sample_valid
);

  // Phase word: 2 quadrant bits plus LUT_WIDTH index bits.
  localparam int PW = LUT_WIDTH + 2;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] ftw_q, ftw_d;
  logic                 v0_q, v0_d;

  logic [LUT_WIDTH-1:0] addr_q, addr_d;
  logic                 neg1_q, v1_q;
  logic                 neg2_q, v2_q;
  logic [LUT_WIDTH:0]   sample_q, sample_d;
  logic                 valid_q;

  logic [PW-1:0]        phase;
  logic [1:0]           quad;
  logic [LUT_WIDTH-1:0] idx;

  // Accumulator and tuning word next state.
  always_comb begin
    acc_d = acc_q;
    ftw_d = ftw_q;
    if (phase_sync) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ftw_q;
    end
    if (ftw_load) begin
      ftw_d = ftw_in;
    end
    v0_d = en | phase_sync;
  end

`ifdef DDS_PHASE_DITHER_EN
  // Bits of acc below the phase LSB; the dither word is left-aligned there.
  localparam int LOW = ACC_WIDTH - PW;

  logic [15:0]          lfsr_q, lfsr_d;
  logic [ACC_WIDTH-1:0] dith;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  generate
    if (LOW >= 16) begin : g_dith_wide
      assign dith = ACC_WIDTH'(lfsr_q) << (LOW - 16);
    end else begin : g_dith_narrow
      // Fewer fraction bits than LFSR bits: keep only the LFSR MSBs.
      assign dith = ACC_WIDTH'(lfsr_q >> (16 - LOW));
    end
  endgenerate

  assign phase = PW'((acc_q + dith) >> (ACC_WIDTH - PW));
`else
  assign phase = acc_q[ACC_WIDTH-1 -: PW];
`endif

  assign quad = phase[PW-1:PW-2];
  assign idx  = phase[LUT_WIDTH-1:0];

  // Quadrants 1 and 3 walk the quarter wave backwards; 2 and 3 are negated.
  always_comb begin
    addr_d   = quad[0] ? ~idx : idx;
    sample_d = neg2_q ? -{1'b0, lut_data} : {1'b0, lut_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      ftw_q    <= '0;
      v0_q     <= 1'b0;
      addr_q   <= '0;
      neg1_q   <= 1'b0;
      v1_q     <= 1'b0;
      neg2_q   <= 1'b0;
      v2_q     <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ftw_q    <= ftw_d;
      v0_q     <= v0_d;
      // Pipeline runs every cycle; only the valid bits follow en.
      addr_q   <= addr_d;
      neg1_q   <= quad[1];
      v1_q     <= v0_q;
      neg2_q   <= neg1_q;
      v2_q     <= v1_q;
      sample_q <= sample_d;
      valid_q  <= v2_q;
    end
  end

  assign lut_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb/tb_dds_phase_acc.sv - scoreboard testbench for dds_phase_acc

module tb_dds_phase_acc;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] ftw_in;
  logic        ftw_load;
  logic        phase_sync;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [8:0]  sample;
  logic        sample_valid;

  int checks;
  int failures;
  int edge_cnt;

  typedef struct {
    logic [8:0] s;
    int         due;
  } exp_t;

  exp_t sbq[$];

  int          lut[256];
  logic [31:0] m_cur;
  logic [31:0] m_old;
  logic [31:0] m_ftw;

  dds_phase_acc #(.ACC_WIDTH(32), .LUT_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ftw_in       (ftw_in),
    .ftw_load     (ftw_load),
    .phase_sync   (phase_sync),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lut_data = 8'd0;
  always @(posedge clk) lut_data <= 8'(lut[lut_addr]);

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Quarter-wave fold: phase = top 10 bits of acc; quadrants 1/3 mirror the index.
  function automatic logic [7:0] addr_of(logic [31:0] a);
    int p;
    int q;
    int i;
    p = int'(a >> 22);
    q = p / 256;
    i = p % 256;
    return 8'((q % 2 == 1) ? 255 - i : i);
  endfunction

  function automatic logic [8:0] sample_of(logic [31:0] a);
    int mag;
    int p;
    mag = lut[addr_of(a)];
    p = int'(a >> 22);
    return 9'((p >= 512) ? -mag : mag);
  endfunction

  // Monitor: pops an expectation when its due edge arrives.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (sample_valid !== 1'b1 || sample !== e.s) begin
          failures++;
          $display("FAIL sample edge=%0d got valid=%0b sample=%h want valid=1 sample=%h",
                   edge_cnt, sample_valid, sample, e.s);
        end
      end else if (sample_valid) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid edge=%0d got sample_valid=1 sample=%h want sample_valid=0",
                 edge_cnt, sample);
      end
    end
  end

  // One clock of stimulus; model acc is advanced with the DUT's edge.
  task automatic step(input logic e, input logic s, input logic l, input logic [31:0] f);
    @(negedge clk);
    checks++;
    if (lut_addr !== addr_of(m_old)) begin
      failures++;
      $display("FAIL lut_addr edge=%0d got %0d want %0d", edge_cnt, lut_addr, addr_of(m_old));
    end
    en         = e;
    phase_sync = s;
    ftw_load   = l;
    ftw_in     = f;
    m_old = m_cur;
    if (s)      m_cur = 32'd0;
    else if (e) m_cur = m_cur + m_ftw;
    if (l)      m_ftw = f;
    if (e || s) sbq.push_back('{s: sample_of(m_cur), due: edge_cnt + 4});
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (lut_addr !== 8'd0 || sample !== 9'd0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s got lut_addr=%0d sample=%h valid=%0b want all 0",
               tag, lut_addr, sample, sample_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 256; k++)
      lut[k] = int'($floor(255.0 * $sin(3.14159265358979 * k / 510.0) + 0.5));
    m_cur = 0;
    m_old = 0;
    m_ftw = 0;
    en = 0;
    phase_sync = 0;
    ftw_load = 0;
    ftw_in = 0;
    rst_n = 0;
    repeat (5) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    check_zero("idle_after_reset");

    // Slow sweep: address climbs 0..255 then folds back.
    step(1'b0, 1'b0, 1'b1, 32'h0040_0000);
    for (int k = 0; k < 520; k++) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Quarter-turn steps: 0, +255, 0, -255.
    step(1'b1, 1'b1, 1'b1, 32'h4000_0000);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Wrap-around from 0xFFC00000.
    step(1'b0, 1'b1, 1'b1, 32'hFFC0_0000);
    step(1'b1, 1'b0, 1'b1, 32'h0040_0000);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Sync and load on the same edge.
    step(1'b1, 1'b1, 1'b1, 32'h8000_0000);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Mid-stream reset: outputs clear without a clock edge.
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_zero("async_reset");
    sbq.delete();
    m_cur = 0;
    m_old = 0;
    m_ftw = 0;
    en = 0;
    phase_sync = 0;
    ftw_load = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    step(1'b0, 1'b0, 1'b1, 32'h0123_4567);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Randomised mix.
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] f;
      f = ($urandom % 2 == 1) ? $urandom : ($urandom >> 8);
      step(($urandom % 4) != 0, ($urandom % 50) == 0, ($urandom % 40) == 0, f);
    end

    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
